// File: rtl/exhaustive_vector_sequencer.sv
// Exhaustive stimulus sweep with settle delay, FWFT record buffer
// and a running 16-bit MISR over every captured {vector, response}.
module exhaustive_vector_sequencer #(
    parameter int N_IN       = 5,
    parameter int N_OUT      = 1,
    parameter int SETTLE     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CK,
    input  logic                  reset,
    input  logic                  start,
    output logic [N_IN-1:0]       dut_n,
    input  logic [N_OUT-1:0]      dut_resp,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [N_IN+N_OUT-1:0] rec_data,
    output logic                  busy,
    output logic                  done,
    output logic [N_IN:0]         vec_count,
    output logic [15:0]           signature
);

    localparam int RW = N_IN + N_OUT;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     occ;
    logic            full;
    logic            push;
    logic            pop;
    logic [RW-1:0]   rec_in;
    logic [15:0]     sig_next;

    // Full is judged on start-of-cycle occupancy, so a same-cycle pop
    // never frees room for a push.
    assign full      = (occ == (AW+1)'(FIFO_DEPTH));
    assign push      = (state == SAMPLE) && !full;
    assign rec_valid = (occ != '0);
    assign pop       = rec_valid && rec_ready;
    assign rec_data  = rec_valid ? mem[rptr] : '0;
    assign rec_in    = {dut_n, dut_resp};
    assign sig_next  = ({signature[14:0], 1'b0}
                       ^ (signature[15] ? 16'h1021 : 16'h0000))
                       ^ 16'(rec_in);

    always_ff @(posedge CK) begin
        if (push) begin
            mem[wptr] <= rec_in;
        end
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state     <= IDLE;
            dut_n     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_count <= '0;
            signature <= 16'hFFFF;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= APPLY;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        dut_n     <= '0;
                        cnt       <= CW'(SETTLE);
                        vec_count <= '0;
                        signature <= 16'hFFFF;
                    end
                end
                APPLY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (!full) begin
                        vec_count <= vec_count + 1'b1;
                        signature <= sig_next;
                        if (&dut_n) begin
                            state <= DRAIN;
                        end else begin
                            dut_n <= dut_n + 1'b1;
                            cnt   <= CW'(SETTLE);
                            state <= APPLY;
                        end
                    end
                end
                DRAIN: begin
                    if (!rec_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
